// File: rtl/apb_master_bridge.sv
// APB initiator: buffers valid/ready commands in a FIFO and
// issues them as APB setup/access transfers with timeout abort.
module apb_master_bridge #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic                       rsp_err,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  state_t state_n;

  logic [AMBA_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [AMBA_WORD-1:0]       data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]      write_mem;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [TW-1:0] wait_cnt;

  logic ready_q;
  logic empty;
  logic push;
  logic pop;
  logic done;
  logic abort;
  logic psel_n;
  logic penable_n;

  assign empty     = (count == '0);
  assign push      = cmd_valid && ready_q;
  assign cmd_ready = ready_q;
  assign busy      = (state != IDLE) || !empty;

  assign done  = (state == ACCESS) && PREADY;
  assign abort = (state == ACCESS) && !PREADY
              && (wait_cnt == TW'(TIMEOUT - 1));
  assign pop   = !empty && ((state == IDLE) || done);

  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!empty) state_n = SETUP;
      end
      SETUP: begin
        state_n = ACCESS;
      end
      ACCESS: begin
        if (done)       state_n = empty ? IDLE : SETUP;
        else if (abort) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    psel_n    = 1'b0;
    penable_n = 1'b0;
    unique case (state_n)
      SETUP: begin
        psel_n = 1'b1;
      end
      ACCESS: begin
        psel_n    = 1'b1;
        penable_n = 1'b1;
      end
      default: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= cmd_addr;
      data_mem[wr_ptr]  <= cmd_wdata;
      write_mem[wr_ptr] <= cmd_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      count     <= count_n;
      ready_q   <= (count_n != CW'(FIFO_DEPTH));
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      rsp_valid <= done || abort;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        PADDR    <= addr_mem[rd_ptr];
        PWDATA   <= data_mem[rd_ptr];
        PWRITE   <= write_mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (done) begin
        rsp_write <= PWRITE;
        rsp_err   <= 1'b0;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (abort) begin
        rsp_write <= PWRITE;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: queue-based transfer model
// compared every cycle, plus directed literal scenarios.
module tb_apb_master_bridge;

  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_write;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  apb_master_bridge #(
    .AMBA_WORD      (DW),
    .AMBA_ADDR_WIDTH(AW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT        (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t q[$];
  bit   active;
  bit   enabled;
  int   waits;

  logic [AW-1:0] e_paddr;
  logic          e_pwrite;
  logic [DW-1:0] e_pwdata;
  logic          e_rv;
  logic          e_rw;
  logic          e_re;
  logic [DW-1:0] e_rd;
  logic          e_ready;

  int errors = 0;
  int checks = 0;
  int rsp_seen = 0;

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one in-flight transfer plus a queue.
  task automatic model_step();
    bit   push;
    bit   can_start;
    cmd_t c;
    if (rst) begin
      q.delete();
      active   = 0;
      enabled  = 0;
      waits    = 0;
      e_paddr  = '0;
      e_pwrite = 1'b0;
      e_pwdata = '0;
      e_rv     = 1'b0;
      e_rw     = 1'b0;
      e_re     = 1'b0;
      e_rd     = '0;
      e_ready  = 1'b0;
      return;
    end
    push      = cmd_valid && e_ready;
    can_start = 0;
    e_rv      = 1'b0;
    if (!active) begin
      can_start = 1;
    end else if (!enabled) begin
      enabled = 1;
    end else if (PREADY) begin
      e_rv   = 1'b1;
      e_rw   = e_pwrite;
      e_re   = 1'b0;
      e_rd   = e_pwrite ? '0 : PRDATA;
      active = 0;
      can_start = 1;
    end else begin
      waits++;
      if (waits == TMO) begin
        e_rv   = 1'b1;
        e_rw   = e_pwrite;
        e_re   = 1'b1;
        e_rd   = '0;
        active = 0;
      end
    end
    if (!active) enabled = 0;
    if (can_start && q.size() > 0) begin
      c        = q.pop_front();
      e_paddr  = c.a;
      e_pwrite = c.w;
      e_pwdata = c.d;
      active   = 1;
      enabled  = 0;
      waits    = 0;
    end
    if (push) begin
      c.w = cmd_write;
      c.a = cmd_addr;
      c.d = cmd_wdata;
      q.push_back(c);
    end
    e_ready = (q.size() != DEPTH);
  endtask

  task automatic compare();
    chk("PSEL", DW'(PSEL), DW'(active));
    chk("PENABLE", DW'(PENABLE), DW'(active && enabled));
    chk("PADDR", DW'(PADDR), DW'(e_paddr));
    chk("PWRITE", DW'(PWRITE), DW'(e_pwrite));
    chk("PWDATA", PWDATA, e_pwdata);
    chk("rsp_valid", DW'(rsp_valid), DW'(e_rv));
    chk("rsp_write", DW'(rsp_write), DW'(e_rw));
    chk("rsp_err", DW'(rsp_err), DW'(e_re));
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("cmd_ready", DW'(cmd_ready), DW'(e_ready));
    chk("busy", DW'(busy), DW'(active || q.size() != 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (rsp_valid === 1'b1) rsp_seen++;
  endtask

  task automatic set_cmd(logic w, logic [AW-1:0] a,
                         logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    int n;
    int pen;
    int acc;
    int base;
    bit got;
    int stuck;
    logic [7:0] ps_v;
    logic [7:0] pe_v;
    logic [7:0] rv_v;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b1;

    // Reset state
    cycle();
    cycle();
    chk("rst_ready", DW'(cmd_ready), 0);
    chk("rst_busy", DW'(busy), 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", DW'(cmd_ready), 1);

    // Single zero-wait write
    set_cmd(1'b1, 20'h00004, 32'hDEADBEEF);
    cycle();
    cmd_valid = 1'b0;
    chk("w_t1_busy", DW'(busy), 1);
    chk("w_t1_psel", DW'(PSEL), 0);
    cycle();
    chk("w_setup_psel", DW'(PSEL), 1);
    chk("w_setup_pen", DW'(PENABLE), 0);
    chk("w_setup_addr", DW'(PADDR), 32'h4);
    chk("w_setup_pwr", DW'(PWRITE), 1);
    chk("w_setup_wd", PWDATA, 32'hDEADBEEF);
    cycle();
    chk("w_access_pen", DW'(PENABLE), 1);
    cycle();
    chk("w_rsp_valid", DW'(rsp_valid), 1);
    chk("w_rsp_write", DW'(rsp_write), 1);
    chk("w_rsp_err", DW'(rsp_err), 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_rsp_psel", DW'(PSEL), 0);
    cycle();
    chk("w_rsp_pulse", DW'(rsp_valid), 0);

    // Read with two wait states
    set_cmd(1'b0, 20'h00010, '0);
    PREADY = 1'b0;
    cycle();
    cmd_valid = 1'b0;
    pen = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (rsp_valid) begin
        got = 1;
        chk("r_rdata", rsp_rdata, 32'h12345678);
      end else if (PENABLE) begin
        pen++;
        chk("r_addr_stable", DW'(PADDR), 32'h10);
        PREADY = (pen == 3);
        PRDATA = 32'h12345678;
      end
    end
    chk("r_got_rsp", DW'(got), 1);
    chk("r_pen_cycles", DW'(pen), 3);
    PREADY = 1'b1;
    cycle();

    // Back-to-back three writes
    ps_v = '0;
    pe_v = '0;
    rv_v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) set_cmd(1'b1, AW'(32'h100 + i), DW'(i + 1));
      else       cmd_valid = 1'b0;
      cycle();
      ps_v = {ps_v[6:0], PSEL};
      pe_v = {pe_v[6:0], PENABLE};
      rv_v = {rv_v[6:0], rsp_valid};
    end
    cmd_valid = 1'b0;
    chk("b2b_psel", DW'(ps_v), 32'h7E);
    chk("b2b_pen", DW'(pe_v), 32'h2A);
    chk("b2b_rsp", DW'(rv_v), 32'h15);

    // Backpressure: stall the slave and fill the FIFO
    PREADY = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      set_cmd(1'b1, AW'(32'h200 + i), $urandom);
      if (cmd_ready) acc++;
      cycle();
      if (!cmd_ready) break;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", DW'(acc), DW'(DEPTH + 1));
    PREADY = 1'b1;
    base = rsp_seen;
    for (int i = 0; i < 30 && rsp_seen - base < acc; i++) cycle();
    chk("bp_responses", DW'(rsp_seen - base), DW'(DEPTH + 1));

    // Timeout abort followed by a queued command
    PREADY = 1'b0;
    set_cmd(1'b0, 20'h00300, '0);
    cycle();
    set_cmd(1'b1, 20'h00020, 32'h55AA55AA);
    cycle();
    cmd_valid = 1'b0;
    pen = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (rsp_valid) got = 1;
      else if (PENABLE) pen++;
    end
    chk("to_got_rsp", DW'(got), 1);
    chk("to_waits", DW'(pen), DW'(TMO));
    chk("to_err", DW'(rsp_err), 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_psel", DW'(PSEL), 0);
    chk("to_pen", DW'(PENABLE), 0);
    PREADY = 1'b1;
    cycle();
    chk("to_next_psel", DW'(PSEL), 1);
    chk("to_next_addr", DW'(PADDR), 32'h20);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (rsp_valid) got = 1;
    end
    chk("to_next_done", DW'(got), 1);
    chk("to_next_err", DW'(rsp_err), 0);

    // Reset during ACCESS with two commands queued
    PREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, AW'(32'h400 + i), DW'(i));
      cycle();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5 && !PENABLE; i++) cycle();
    chk("mr_in_access", DW'(PENABLE), 1);
    rst = 1'b1;
    cycle();
    chk("mr_psel", DW'(PSEL), 0);
    chk("mr_pen", DW'(PENABLE), 0);
    chk("mr_rsp", DW'(rsp_valid), 0);
    chk("mr_busy", DW'(busy), 0);
    rst = 1'b0;
    cycle();
    chk("mr_ready", DW'(cmd_ready), 1);
    PREADY = 1'b1;
    PRDATA = 32'hCAFEF00D;
    set_cmd(1'b0, 20'h00030, '0);
    cycle();
    cmd_valid = 1'b0;
    n = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      n++;
      if (rsp_valid) got = 1;
    end
    chk("mr_latency", DW'(n), 3);
    chk("mr_rdata", rsp_rdata, 32'hCAFEF00D);

    // Randomized traffic against the model
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_write = $urandom_range(0, 1) == 1;
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      PRDATA    = $urandom;
      if (stuck > 0) begin
        PREADY = 1'b0;
        stuck--;
      end else if ($urandom_range(0, 99) == 0) begin
        PREADY = 1'b0;
        stuck  = 20;
      end else begin
        PREADY = $urandom_range(0, 3) != 0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that converts a simple valid/ready command stream into APB setup/access transfers toward the register-mapped slave DUT.
- Returns read data and completion status on a one-cycle response strobe.
- Buffers up to FIFO_DEPTH commands, supports PREADY wait states, and aborts a hung transfer after TIMEOUT cycles.
- Sits between the stimulus/sequencer logic and the APB slave port.

Parameters:
AMBA_WORD, 32, APB data width (PWDATA/PRDATA/cmd_wdata/rsp_rdata)
AMBA_ADDR_WIDTH, 20, APB address width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=1)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_write  input  1  1=write, 0=read
cmd_addr  input  AMBA_ADDR_WIDTH  target address
cmd_wdata  input  AMBA_WORD  write data (ignored for reads)
rsp_valid  output  1  one-cycle completion pulse, no backpressure
rsp_write  output  1  type of completed transfer
rsp_err  output  1  1=transfer aborted by timeout
rsp_rdata  output  AMBA_WORD  captured PRDATA for a read; 0 for a write or an error
busy  output  1  FSM not IDLE or FIFO not empty
PADDR  output  AMBA_ADDR_WIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  AMBA_WORD  APB write data
PRDATA  input  AMBA_WORD  APB read data
PREADY  input  1  APB ready (tie 1 for zero-wait slaves)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst high at an edge): all outputs 0, except cmd_ready=1 the cycle after rst falls.
  - FIFO flushed, FSM to IDLE, wait counter 0.
  - Reset during SETUP/ACCESS drops PSEL/PENABLE at that edge and produces no response.
- Command FIFO:
  - Push when cmd_valid && cmd_ready at an edge.
  - cmd_ready = !full (registered occupancy), so there is never a push into a full FIFO.
  - Pop and push in the same cycle are allowed; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH, and the occupancy counter is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
  - IDLE: PSEL=0, PENABLE=0. If the FIFO is non-empty, pop the head, load PADDR/PWRITE/PWDATA, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: transfer completes. Capture PRDATA if PWRITE=0. Next cycle rsp_valid=1 with rsp_err=0.
      - If the FIFO is non-empty, pop and go directly to SETUP (PSEL stays 1, PENABLE drops to 0, new address/data loaded).
      - Otherwise go to IDLE.
    - PREADY=0: increment the wait counter. When it reaches TIMEOUT with PREADY still 0, abort.
      - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0, PENABLE=0.
      - FSM goes to IDLE for at least one cycle before the next command.
    - The wait counter clears on entry to SETUP.
- PADDR/PWRITE/PWDATA are stable from SETUP through the final ACCESS cycle. After completion they hold their last values (not zeroed).
- Latency, zero-wait:
  - Command accepted at edge ending cycle T.
  - SETUP in cycle T+2, ACCESS in T+3, rsp_valid in T+4.
- Throughput: back-to-back transfers take 2 cycles each (SETUP+ACCESS), with no idle cycle between.
- rsp_valid is high for exactly one cycle per transfer. rsp_write/rsp_rdata/rsp_err are valid only with rsp_valid and hold otherwise.
- busy=1 from the cycle after the first push until the FSM is IDLE and the FIFO is empty.

Test Plan:
- Single write, PREADY=1: cmd write addr=0x00004 data=0xDEADBEEF at T -> SETUP T+2 (PSEL=1,PENABLE=0,PADDR=0x4,PWRITE=1,PWDATA=0xDEADBEEF), ACCESS T+3, rsp_valid=1 rsp_write=1 rsp_err=0 rsp_rdata=0 at T+4, PSEL=0 at T+4.
- Read with 2 wait states: read addr=0x10, PREADY low for 2 ACCESS cycles, then high with PRDATA=0x12345678 -> PENABLE high 3 cycles, address stable throughout, rsp_valid once with rsp_rdata=0x12345678.
- Back-to-back: push 3 commands on consecutive cycles -> PSEL continuously 1 for 6 cycles, PENABLE pattern 0,1,0,1,0,1, three rsp_valid pulses 2 cycles apart in order.
- Backpressure: hold PREADY=0 (TIMEOUT large), push until cmd_ready=0 -> exactly FIFO_DEPTH commands accepted beyond the in-flight one; no loss after PREADY released, FIFO_DEPTH+1 responses in order.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> abort after 16 waiting ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL/PENABLE=0 next cycle, next queued command proceeds normally.
- Reset mid-ACCESS: assert rst during ACCESS with 2 commands queued -> next edge all outputs 0, no rsp_valid, busy=0, cmd_ready=1 after release, fresh command completes with nominal latency.
